// File: rtl/ps2_keycode_receiver.sv
// PS/2 keyboard receiver: conditions the PS/2 lines, deserialises frames and decodes E0/F0 prefixes into make-code strobes.
// Define TYPEMATIC_SUPPRESS_EN to suppress strobes for auto-repeated makes of the key currently held down.
module ps2_keycode_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk100MHz,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       newKeyStrobe,
  output logic       extended,
  output logic       frameError
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } stateType;

  logic [1:0]    clkSync;
  logic [1:0]    dataSync;
  logic          clkFilt;
  logic [FW-1:0] filterCount;
  logic          filterDone;
  logic          fallEdge;
  logic          dataBit;

  stateType      state, stateNext;
  logic [3:0]    bitCount, bitCountNext;
  logic [8:0]    shiftReg, shiftRegNext;
  logic [TW-1:0] timeoutCount, timeoutCountNext;
  logic          extFlag, extFlagNext;
  logic          brkFlag, brkFlagNext;
  logic [7:0]    keycodeNext;
  logic          extendedNext;
  logic          strobeNext;
  logic          errorNext;
  logic          frameOk;
  logic [7:0]    rxByte;

`ifdef TYPEMATIC_SUPPRESS_EN
  logic          heldValid, heldValidNext;
  logic [8:0]    heldCode, heldCodeNext;
  logic          heldMatch;
`endif

  // Idle PS/2 lines are high, so synchronisers and filter come out of reset at 1
  always_ff @(posedge clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      clkSync     <= 2'b11;
      dataSync    <= 2'b11;
      clkFilt     <= 1'b1;
      filterCount <= '0;
    end else begin
      clkSync  <= {clkSync[0], ps2_clk};
      dataSync <= {dataSync[0], ps2_data};
      if (clkSync[1] != clkFilt) begin
        if (filterDone) begin
          clkFilt     <= clkSync[1];
          filterCount <= '0;
        end else begin
          filterCount <= filterCount + 1'b1;
        end
      end else begin
        filterCount <= '0;
      end
    end
  end

  assign filterDone = (clkSync[1] != clkFilt) && (filterCount == FW'(FILTER_LEN - 1));
  assign fallEdge   = filterDone && clkFilt;
  assign dataBit    = dataSync[1];

  // Odd parity over data plus parity bit, and the stop bit arriving on this edge must be 1
  assign frameOk = (^shiftReg) && dataBit;
  assign rxByte  = shiftReg[7:0];

`ifdef TYPEMATIC_SUPPRESS_EN
  assign heldMatch = heldValid && (heldCode == {extFlag, rxByte});
`endif

  always_ff @(posedge clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bitCount     <= '0;
      shiftReg     <= '0;
      timeoutCount <= '0;
      extFlag      <= 1'b0;
      brkFlag      <= 1'b0;
      keycode      <= 8'h00;
      extended     <= 1'b0;
      newKeyStrobe <= 1'b0;
      frameError   <= 1'b0;
`ifdef TYPEMATIC_SUPPRESS_EN
      heldValid    <= 1'b0;
      heldCode     <= '0;
`endif
    end else begin
      state        <= stateNext;
      bitCount     <= bitCountNext;
      shiftReg     <= shiftRegNext;
      timeoutCount <= timeoutCountNext;
      extFlag      <= extFlagNext;
      brkFlag      <= brkFlagNext;
      keycode      <= keycodeNext;
      extended     <= extendedNext;
      newKeyStrobe <= strobeNext;
      frameError   <= errorNext;
`ifdef TYPEMATIC_SUPPRESS_EN
      heldValid    <= heldValidNext;
      heldCode     <= heldCodeNext;
`endif
    end
  end

  // The frame is judged on the stop-bit edge so the registered pulses line up with the CHECK cycle
  always_comb begin
    stateNext        = state;
    bitCountNext     = bitCount;
    shiftRegNext     = shiftReg;
    timeoutCountNext = timeoutCount;
    extFlagNext      = extFlag;
    brkFlagNext      = brkFlag;
    keycodeNext      = keycode;
    extendedNext     = extended;
    strobeNext       = 1'b0;
    errorNext        = 1'b0;
`ifdef TYPEMATIC_SUPPRESS_EN
    heldValidNext    = heldValid;
    heldCodeNext     = heldCode;
`endif

    unique case (state)
      IDLE: begin
        if (fallEdge && !dataBit) begin
          stateNext        = SHIFT;
          bitCountNext     = '0;
          timeoutCountNext = '0;
        end
      end

      SHIFT: begin
        if (fallEdge) begin
          timeoutCountNext = '0;
          if (bitCount == 4'd9) begin
            stateNext = CHECK;
            if (!frameOk) begin
              errorNext   = 1'b1;
              extFlagNext = 1'b0;
              brkFlagNext = 1'b0;
            end else if (rxByte == 8'hE0) begin
              extFlagNext = 1'b1;
            end else if (rxByte == 8'hF0) begin
              brkFlagNext = 1'b1;
            end else if (brkFlag) begin
              extFlagNext = 1'b0;
              brkFlagNext = 1'b0;
`ifdef TYPEMATIC_SUPPRESS_EN
              if (heldMatch) begin
                heldValidNext = 1'b0;
              end
`endif
            end else begin
              extFlagNext = 1'b0;
`ifdef TYPEMATIC_SUPPRESS_EN
              if (!heldMatch) begin
                keycodeNext   = rxByte;
                extendedNext  = extFlag;
                strobeNext    = 1'b1;
                heldValidNext = 1'b1;
                heldCodeNext  = {extFlag, rxByte};
              end
`else
              keycodeNext  = rxByte;
              extendedNext = extFlag;
              strobeNext   = 1'b1;
`endif
            end
          end else begin
            shiftRegNext = {dataBit, shiftReg[8:1]};
            bitCountNext = bitCount + 4'd1;
          end
        end else if (timeoutCount >= TW'(TIMEOUT_CYCLES - 1)) begin
          errorNext   = 1'b1;
          extFlagNext = 1'b0;
          brkFlagNext = 1'b0;
          stateNext   = IDLE;
        end else begin
          timeoutCountNext = timeoutCount + 1'b1;
        end
      end

      CHECK: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule
